// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and its datapath (slave):
// IR/PSW fields flow into the controller, per-cycle strobes flow back out.
interface multicycle_controller_if;
  logic [4:0] opcode;
  logic [1:0] ALUopcode;
  logic [2:0] PSW_NZC;
  logic       Buff_MEMIns;
  logic       MEMresource;
  logic       WE_MEM;
  logic       ALUorNot;
  logic       LIorMOV;
  logic       RBresource;
  logic       oprandB;
  logic       LI;
  logic       WBresource;
  logic       PCplus1orWB;
  logic       WE_RF;
  logic       Flag;
  logic       ALUop;
  logic       Buff_PSW;
  logic       Branch;
  logic [1:0] Jump;
  logic       Buff_PC;
  logic       done;

  modport master (
    input  opcode, ALUopcode, PSW_NZC,
    output Buff_MEMIns, MEMresource, WE_MEM, ALUorNot, LIorMOV,
    output RBresource, oprandB, LI, WBresource, PCplus1orWB, WE_RF,
    output Flag, ALUop, Buff_PSW, Branch, Jump, Buff_PC, done
  );

  modport slave (
    output opcode, ALUopcode, PSW_NZC,
    input  Buff_MEMIns, MEMresource, WE_MEM, ALUorNot, LIorMOV,
    input  RBresource, oprandB, LI, WBresource, PCplus1orWB, WE_RF,
    input  Flag, ALUop, Buff_PSW, Branch, Jump, Buff_PC, done
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle control unit: steps IF/ID/EX/MEM/WB (plus HALT) and decodes datapath
// strobes combinationally from the current state, the IR opcode and the live PSW flags.
module multicycle_controller (
  input logic                    clk,
  input logic                    Rst,
  multicycle_controller_if.master bus
);
  localparam logic [4:0] OP_ALU   = 5'b00000;
  localparam logic [4:0] OP_CMP   = 5'b00001;
  localparam logic [4:0] OP_ADDI  = 5'b00010;
  localparam logic [4:0] OP_SUBI  = 5'b00011;
  localparam logic [4:0] OP_MOV   = 5'b00100;
  localparam logic [4:0] OP_LHI   = 5'b00101;
  localparam logic [4:0] OP_LLI   = 5'b00110;
  localparam logic [4:0] OP_LDRRI = 5'b00111;
  localparam logic [4:0] OP_LDRRR = 5'b01000;
  localparam logic [4:0] OP_STRRI = 5'b01001;
  localparam logic [4:0] OP_STRRR = 5'b01010;
  localparam logic [4:0] OP_BCC   = 5'b10000;
  localparam logic [4:0] OP_BCS   = 5'b10001;
  localparam logic [4:0] OP_BNE   = 5'b10010;
  localparam logic [4:0] OP_BEQ   = 5'b10011;
  localparam logic [4:0] OP_BAL   = 5'b10100;
  localparam logic [4:0] OP_JMP   = 5'b11000;
  localparam logic [4:0] OP_JALRL = 5'b11001;
  localparam logic [4:0] OP_JALRR = 5'b11010;
  localparam logic [4:0] OP_JR    = 5'b11011;
  localparam logic [4:0] OP_HLT   = 5'b11111;

  typedef enum logic [2:0] {
    S_RST, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_t;

  state_t state;

  logic is_ldr;
  logic is_str;
  logic is_hlt;
  logic to_ex;
  logic flag_c;
  logic flag_z;
  logic flag_n_unused;

  assign flag_c        = bus.PSW_NZC[0];
  assign flag_z        = bus.PSW_NZC[1];
  assign flag_n_unused = bus.PSW_NZC[2];

  assign is_ldr = (bus.opcode == OP_LDRRI) || (bus.opcode == OP_LDRRR);
  assign is_str = (bus.opcode == OP_STRRI) || (bus.opcode == OP_STRRR);
  assign is_hlt = (bus.opcode == OP_HLT);
  // Only the data-processing and load/store opcodes continue past ID.
  assign to_ex  = (bus.opcode inside {OP_ALU, OP_CMP, OP_ADDI, OP_SUBI, OP_MOV, OP_LHI,
                                      OP_LLI, OP_LDRRI, OP_LDRRR, OP_STRRI, OP_STRRR});

  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST:   state <= S_IF;
        S_IF:    state <= S_ID;
        S_ID:    state <= is_hlt ? S_HALT : (to_ex ? S_EX : S_IF);
        S_EX:    state <= (bus.opcode == OP_CMP) ? S_IF : S_MEM;
        S_MEM:   state <= is_str ? S_IF : S_WB;
        S_WB:    state <= S_IF;
        S_HALT:  state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  always_comb begin
    bus.Buff_MEMIns = 1'b0;
    bus.MEMresource = 1'b0;
    bus.WE_MEM      = 1'b0;
    bus.ALUorNot    = 1'b0;
    bus.LIorMOV     = 1'b0;
    bus.RBresource  = 1'b0;
    bus.oprandB     = 1'b0;
    bus.LI          = 1'b0;
    bus.WBresource  = 1'b0;
    bus.PCplus1orWB = 1'b0;
    bus.WE_RF       = 1'b0;
    bus.Flag        = 1'b0;
    bus.ALUop       = 1'b0;
    bus.Buff_PSW    = 1'b0;
    bus.Branch      = 1'b0;
    bus.Jump        = 2'b00;
    bus.Buff_PC     = 1'b0;
    bus.done        = 1'b0;

    case (state)
      S_IF: bus.Buff_MEMIns = 1'b1;

      S_ID: begin
        case (bus.opcode)
          OP_LHI: begin
            bus.RBresource = 1'b1;
            bus.LI         = 1'b1;
          end
          OP_ADDI, OP_SUBI, OP_LDRRI, OP_STRRI: bus.oprandB = 1'b1;
          OP_BCC: begin bus.Branch = ~flag_c; bus.Buff_PC = 1'b1; end
          OP_BCS: begin bus.Branch = flag_c;  bus.Buff_PC = 1'b1; end
          OP_BNE: begin bus.Branch = ~flag_z; bus.Buff_PC = 1'b1; end
          OP_BEQ: begin bus.Branch = flag_z;  bus.Buff_PC = 1'b1; end
          OP_BAL: begin bus.Branch = 1'b1;    bus.Buff_PC = 1'b1; end
          OP_JMP: begin bus.Jump = 2'b01;     bus.Buff_PC = 1'b1; end
          OP_JALRL: begin
            bus.Branch  = 1'b1;
            bus.WE_RF   = 1'b1;
            bus.Buff_PC = 1'b1;
          end
          OP_JALRR: begin
            bus.Jump    = 2'b10;
            bus.WE_RF   = 1'b1;
            bus.Buff_PC = 1'b1;
          end
          OP_JR: begin
            bus.Jump       = 2'b11;
            bus.RBresource = 1'b1;
            bus.Buff_PC    = 1'b1;
          end
          // OutR, HLT and every unmapped opcode just advance the PC here.
          default: bus.Buff_PC = ~to_ex;
        endcase
      end

      S_EX: begin
        case (bus.opcode)
          OP_ALU: begin
            bus.Flag     = bus.ALUopcode[0];
            bus.ALUop    = bus.ALUopcode[1];
            bus.Buff_PSW = 1'b1;
          end
          OP_ADDI: bus.Buff_PSW = 1'b1;
          OP_SUBI: begin bus.ALUop = 1'b1; bus.Buff_PSW = 1'b1; end
          OP_CMP: begin
            bus.ALUop    = 1'b1;
            bus.Buff_PSW = 1'b1;
            bus.Buff_PC  = 1'b1;
          end
          OP_STRRI, OP_STRRR: bus.RBresource = 1'b1;
          default: ;
        endcase
      end

      S_MEM: begin
        case (bus.opcode)
          OP_MOV: begin bus.ALUorNot = 1'b1; bus.LIorMOV = 1'b1; end
          OP_LHI, OP_LLI: bus.ALUorNot = 1'b1;
          OP_LDRRI, OP_LDRRR: bus.MEMresource = 1'b1;
          OP_STRRI, OP_STRRR: begin
            bus.MEMresource = 1'b1;
            bus.WE_MEM      = 1'b1;
            bus.Buff_PC     = 1'b1;
          end
          default: ;
        endcase
      end

      S_WB: begin
        bus.WE_RF       = 1'b1;
        bus.Buff_PC     = 1'b1;
        bus.WBresource  = is_ldr;
        bus.PCplus1orWB = ~is_ldr;
      end

      S_HALT: bus.done = 1'b1;

      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model expands each
// instruction into its expected per-cycle control vectors, checked every cycle.
module tb_multicycle_controller;
  typedef struct packed {
    logic       buff_memins;
    logic       memresource;
    logic       we_mem;
    logic       aluornot;
    logic       liormov;
    logic       rbresource;
    logic       oprandb;
    logic       li;
    logic       wbresource;
    logic       pcplus1orwb;
    logic       we_rf;
    logic       flag;
    logic       aluop;
    logic       buff_psw;
    logic       branch;
    logic [1:0] jump;
    logic       buff_pc;
    logic       done;
  } ctl_t;

  localparam logic [4:0] OP_ALU   = 5'b00000;
  localparam logic [4:0] OP_CMP   = 5'b00001;
  localparam logic [4:0] OP_ADDI  = 5'b00010;
  localparam logic [4:0] OP_SUBI  = 5'b00011;
  localparam logic [4:0] OP_MOV   = 5'b00100;
  localparam logic [4:0] OP_LHI   = 5'b00101;
  localparam logic [4:0] OP_LLI   = 5'b00110;
  localparam logic [4:0] OP_LDRRI = 5'b00111;
  localparam logic [4:0] OP_LDRRR = 5'b01000;
  localparam logic [4:0] OP_STRRI = 5'b01001;
  localparam logic [4:0] OP_STRRR = 5'b01010;
  localparam logic [4:0] OP_BCC   = 5'b10000;
  localparam logic [4:0] OP_BCS   = 5'b10001;
  localparam logic [4:0] OP_BNE   = 5'b10010;
  localparam logic [4:0] OP_BEQ   = 5'b10011;
  localparam logic [4:0] OP_BAL   = 5'b10100;
  localparam logic [4:0] OP_JMP   = 5'b11000;
  localparam logic [4:0] OP_JALRL = 5'b11001;
  localparam logic [4:0] OP_JALRR = 5'b11010;
  localparam logic [4:0] OP_JR    = 5'b11011;
  localparam logic [4:0] OP_OUTR  = 5'b11100;
  localparam logic [4:0] OP_HLT   = 5'b11111;
  localparam logic [4:0] OP_UNMAP = 5'b01101;

  logic clk = 1'b0;
  logic rst;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .Rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  ctl_t act;
  assign act = {bus.Buff_MEMIns, bus.MEMresource, bus.WE_MEM, bus.ALUorNot, bus.LIorMOV,
                bus.RBresource, bus.oprandB, bus.LI, bus.WBresource, bus.PCplus1orWB,
                bus.WE_RF, bus.Flag, bus.ALUop, bus.Buff_PSW, bus.Branch, bus.Jump,
                bus.Buff_PC, bus.done};

  ctl_t  exp_q[$];
  string tag_q[$];
  ctl_t  seen_q[$];
  ctl_t  plan_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic pin(input string name, input logic got, input logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic step(input ctl_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model: what each cycle of one instruction must do.
  task automatic build_plan(input logic [4:0] op, input logic [1:0] alu, input logic [2:0] psw);
    ctl_t c;
    logic ld, st, multi;
    ld    = (op == OP_LDRRI) || (op == OP_LDRRR);
    st    = (op == OP_STRRI) || (op == OP_STRRR);
    multi = (op inside {OP_ALU, OP_CMP, OP_ADDI, OP_SUBI, OP_MOV, OP_LHI, OP_LLI}) || ld || st;
    plan_q.delete();

    c = '0;
    c.buff_memins = 1'b1;
    plan_q.push_back(c);

    c = '0;
    case (op)
      OP_LHI:   begin c.rbresource = 1'b1; c.li = 1'b1; end
      OP_ADDI, OP_SUBI, OP_LDRRI, OP_STRRI: c.oprandb = 1'b1;
      OP_BCC:   begin c.branch = (psw[0] == 1'b0); c.buff_pc = 1'b1; end
      OP_BCS:   begin c.branch = (psw[0] == 1'b1); c.buff_pc = 1'b1; end
      OP_BNE:   begin c.branch = (psw[1] == 1'b0); c.buff_pc = 1'b1; end
      OP_BEQ:   begin c.branch = (psw[1] == 1'b1); c.buff_pc = 1'b1; end
      OP_BAL:   begin c.branch = 1'b1; c.buff_pc = 1'b1; end
      OP_JMP:   begin c.jump = 2'd1; c.buff_pc = 1'b1; end
      OP_JALRL: begin c.branch = 1'b1; c.we_rf = 1'b1; c.buff_pc = 1'b1; end
      OP_JALRR: begin c.jump = 2'd2; c.we_rf = 1'b1; c.buff_pc = 1'b1; end
      OP_JR:    begin c.jump = 2'd3; c.rbresource = 1'b1; c.buff_pc = 1'b1; end
      default:  c.buff_pc = !multi;
    endcase
    plan_q.push_back(c);
    if (!multi) return;

    c = '0;
    case (op)
      OP_ALU: begin
        c.flag     = (alu == 2'b01) || (alu == 2'b11);  // ADC, SBB consume carry
        c.aluop    = (alu == 2'b10) || (alu == 2'b11);  // SUB, SBB subtract
        c.buff_psw = 1'b1;
      end
      OP_ADDI: c.buff_psw = 1'b1;
      OP_SUBI: begin c.aluop = 1'b1; c.buff_psw = 1'b1; end
      OP_CMP:  begin c.aluop = 1'b1; c.buff_psw = 1'b1; c.buff_pc = 1'b1; end
      default: c.rbresource = st;
    endcase
    plan_q.push_back(c);
    if (op == OP_CMP) return;

    c = '0;
    if (op == OP_MOV) begin c.aluornot = 1'b1; c.liormov = 1'b1; end
    if (op == OP_LHI || op == OP_LLI) c.aluornot = 1'b1;
    if (ld || st) c.memresource = 1'b1;
    if (st) begin c.we_mem = 1'b1; c.buff_pc = 1'b1; end
    plan_q.push_back(c);
    if (st) return;

    c = '0;
    c.we_rf       = 1'b1;
    c.buff_pc     = 1'b1;
    c.wbresource  = ld;
    c.pcplus1orwb = !ld;
    plan_q.push_back(c);
  endtask

  task automatic run(input logic [4:0] op, input logic [1:0] alu, input logic [2:0] psw,
                     input string name);
    bus.opcode    = op;
    bus.ALUopcode = alu;
    bus.PSW_NZC   = psw;
    build_plan(op, alu, psw);
    for (int i = 0; i < plan_q.size(); i++) step(plan_q[i], $sformatf("%s c%0d", name, i));
  endtask

  initial begin
    ctl_t zero;
    ctl_t halted;
    zero        = '0;
    halted      = '0;
    halted.done = 1'b1;

    rst           = 1'b1;
    bus.opcode    = OP_LLI;
    bus.ALUopcode = 2'b00;
    bus.PSW_NZC   = 3'b000;

    fork
      forever begin
        ctl_t  e;
        string t;
        @(negedge clk);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          total++;
          if (act !== e) begin
            bad++;
            $display("FAIL %s: got %b want %b", t, act, e);
          end
          seen_q.push_back(act);
        end
      end
    join_none

    @(posedge clk);
    #1;
    step(zero, "rst0");
    step(zero, "rst1");
    pin("rst_done", seen_q[$].done, 1'b0);
    rst = 1'b0;
    step(zero, "rst_release");

    run(OP_LLI, 2'b00, 3'b000, "lli");
    pin("lli_if_no_we_rf", seen_q[$-4].we_rf, 1'b0);
    pin("lli_if_no_pc", seen_q[$-4].buff_pc, 1'b0);
    pin("lli_mem_aluornot", seen_q[$-1].aluornot, 1'b1);
    pin("lli_mem_liormov", seen_q[$-1].liormov, 1'b0);
    pin("lli_wb_we_rf", seen_q[$].we_rf, 1'b1);
    pin("lli_wb_pcplus1", seen_q[$].pcplus1orwb, 1'b1);
    pin("lli_wb_pc", seen_q[$].buff_pc, 1'b1);

    run(OP_CMP, 2'b11, 3'b000, "cmp");
    pin("cmp_ex_aluop", seen_q[$].aluop, 1'b1);
    pin("cmp_ex_psw", seen_q[$].buff_psw, 1'b1);
    pin("cmp_ex_pc", seen_q[$].buff_pc, 1'b1);

    for (int a = 0; a < 4; a++) run(OP_ALU, 2'(a), 3'b101, $sformatf("alu%0d", a));
    pin("sbb_ex_flag", seen_q[$-2].flag, 1'b1);
    pin("sbb_ex_aluop", seen_q[$-2].aluop, 1'b1);
    run(OP_ADDI, 2'b00, 3'b000, "addi");
    run(OP_SUBI, 2'b00, 3'b000, "subi");
    run(OP_MOV, 2'b00, 3'b000, "mov");
    run(OP_LHI, 2'b00, 3'b000, "lhi");
    run(OP_LDRRI, 2'b00, 3'b000, "ldrri");
    pin("ldr_wb_wbres", seen_q[$].wbresource, 1'b1);
    run(OP_LDRRR, 2'b00, 3'b000, "ldrrr");

    run(OP_STRRI, 2'b00, 3'b000, "strri");
    pin("str_id_oprandb", seen_q[$-2].oprandb, 1'b1);
    pin("str_ex_rbres", seen_q[$-1].rbresource, 1'b1);
    pin("str_mem_we_mem", seen_q[$].we_mem, 1'b1);
    run(OP_STRRR, 2'b00, 3'b000, "strrr");

    run(OP_BEQ, 2'b00, 3'b010, "beq_z1");
    pin("beq_taken", seen_q[$].branch, 1'b1);
    run(OP_BEQ, 2'b00, 3'b000, "beq_z0");
    pin("beq_not_taken", seen_q[$].branch, 1'b0);
    pin("beq_pc", seen_q[$].buff_pc, 1'b1);
    for (int p = 0; p < 8; p += 3) begin
      run(OP_BCC, 2'b00, 3'(p), $sformatf("bcc_%0d", p));
      run(OP_BCS, 2'b00, 3'(p), $sformatf("bcs_%0d", p));
      run(OP_BNE, 2'b00, 3'(p), $sformatf("bne_%0d", p));
    end
    run(OP_BAL, 2'b00, 3'b000, "bal");
    run(OP_JMP, 2'b00, 3'b000, "jmp");
    run(OP_JALRL, 2'b00, 3'b000, "jalrl");
    run(OP_JALRR, 2'b00, 3'b000, "jalrr");
    run(OP_JR, 2'b00, 3'b000, "jr");
    run(OP_OUTR, 2'b00, 3'b000, "outr");
    run(OP_UNMAP, 2'b00, 3'b000, "unmapped");

    // Reset lands on the MEM edge of a load: the write-back must never happen.
    bus.opcode = OP_LDRRR;
    build_plan(OP_LDRRR, 2'b00, 3'b000);
    for (int i = 0; i < 3; i++) step(plan_q[i], $sformatf("ldr_abort c%0d", i));
    rst = 1'b1;
    step(plan_q[3], "ldr_abort mem");
    rst = 1'b0;
    step(zero, "ldr_abort rst");
    pin("ldr_abort_no_we_rf", seen_q[$].we_rf, 1'b0);
    run(OP_ADDI, 2'b00, 3'b000, "addi_after_abort");

    run(OP_HLT, 2'b00, 3'b000, "hlt");
    for (int i = 0; i < 10; i++) step(halted, $sformatf("halt%0d", i));
    pin("halt_done_first", seen_q[$-9].done, 1'b1);
    pin("halt_done_last", seen_q[$].done, 1'b1);
    rst = 1'b1;
    step(halted, "halt_rst_edge");
    rst = 1'b0;
    step(zero, "halt_rst");
    pin("halt_rst_done", seen_q[$].done, 1'b0);
    run(OP_OUTR, 2'b00, 3'b000, "outr_after_halt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
